// File: rtl/chimp_sequencer.sv
// rtl/chimp_sequencer.sv - Memory-game round sequencer: load numbers, reveal, judge picks, track level and strikes.
// All outputs are registered; iKey0 overrides every state transition.
module chimp_sequencer #(
    parameter int START_NUMS  = 4,
    parameter int MAX_NUMS    = 9,
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iKey0,
    input  logic       iEnter,
    input  logic       iDoneLoad,
    input  logic       iClickValid,
    input  logic [4:0] iClickNum,
    output logic       oResetBoard,
    output logic       oLoadEnable,
    output logic [4:0] oNumToLoad,
    output logic       oShowEnable,
    output logic [4:0] oNumToChoose,
    output logic [4:0] oLevel,
    output logic [1:0] oStrikes,
    output logic       oCorrect,
    output logic       oWrong,
    output logic       oGameOver,
    output logic [2:0] oState
);
    typedef enum logic [2:0] {
        S_MENU     = 3'd0,
        S_CLEAR    = 3'd1,
        S_LOAD     = 3'd2,
        S_SHOW     = 3'd3,
        S_PLAY     = 3'd4,
        S_WIN      = 3'd5,
        S_STRIKE   = 3'd6,
        S_GAMEOVER = 3'd7
    } state_t;

    localparam logic [6:0] L_START       = 7'(START_NUMS);
    localparam logic [6:0] L_MAX_NUMS    = 7'(MAX_NUMS);
    localparam logic [1:0] L_MAX_STRIKES = 2'(MAX_STRIKES);

    state_t     r_state;
    logic [4:0] r_level, r_num_load, r_num_choose;
    logic [1:0] r_strikes;
    logic       r_reset_board, r_load_en, r_show, r_correct, r_wrong, r_game_over;

    // Numbers on the board this level, capped at board capacity.
    logic [6:0] w_sum;
    logic [4:0] w_count;
    logic       w_click;
    logic [1:0] w_strikes_next;

    assign w_sum          = L_START + {2'b00, r_level} - 7'd1;
    assign w_count        = (w_sum > L_MAX_NUMS) ? L_MAX_NUMS[4:0] : w_sum[4:0];
    assign w_click        = iClickValid && (iClickNum != 5'd0);
    assign w_strikes_next = r_strikes + 2'd1;

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            r_state       <= S_MENU;
            r_level       <= 5'd0;
            r_strikes     <= 2'd0;
            r_num_load    <= 5'd0;
            r_num_choose  <= 5'd0;
            r_reset_board <= 1'b0;
            r_load_en     <= 1'b0;
            r_show        <= 1'b0;
            r_correct     <= 1'b0;
            r_wrong       <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            if (iKey0) begin
                r_state       <= S_MENU;
                r_level       <= 5'd0;
                r_strikes     <= 2'd0;
                r_num_load    <= 5'd0;
                r_num_choose  <= 5'd0;
                r_reset_board <= 1'b0;
                r_load_en     <= 1'b0;
                r_show        <= 1'b0;
                r_game_over   <= 1'b0;
            end else begin
                case (r_state)
                    S_MENU: if (iEnter) begin
                        r_state       <= S_CLEAR;
                        r_level       <= 5'd1;
                        r_strikes     <= 2'd0;
                        r_num_load    <= 5'd1;
                        r_reset_board <= 1'b1;
                    end
                    S_CLEAR: begin
                        r_state       <= S_LOAD;
                        r_reset_board <= 1'b0;
                        r_load_en     <= 1'b1;
                    end
                    S_LOAD: if (iDoneLoad) begin
                        if (r_num_load < w_count) begin
                            r_num_load <= r_num_load + 5'd1;
                        end else begin
                            r_state      <= S_SHOW;
                            r_load_en    <= 1'b0;
                            r_show       <= 1'b1;
                            r_num_choose <= 5'd1;
                        end
                    end
                    S_SHOW, S_PLAY: if (w_click) begin
                        r_show <= 1'b0;
                        if (iClickNum == r_num_choose) begin
                            r_correct <= 1'b1;
                            if (r_num_choose == w_count) begin
                                r_state <= S_WIN;
                            end else begin
                                r_state      <= S_PLAY;
                                r_num_choose <= r_num_choose + 5'd1;
                            end
                        end else begin
                            r_wrong <= 1'b1;
                            r_state <= S_STRIKE;
                        end
                    end
                    S_WIN: begin
                        if (r_level != 5'd31) r_level <= r_level + 5'd1;
                        r_state       <= S_CLEAR;
                        r_num_load    <= 5'd1;
                        r_reset_board <= 1'b1;
                    end
                    S_STRIKE: begin
                        r_strikes <= w_strikes_next;
                        if (w_strikes_next == L_MAX_STRIKES) begin
                            r_state     <= S_GAMEOVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state       <= S_CLEAR;
                            r_num_load    <= 5'd1;
                            r_reset_board <= 1'b1;
                        end
                    end
                    S_GAMEOVER: if (iEnter) begin
                        r_state      <= S_MENU;
                        r_level      <= 5'd0;
                        r_strikes    <= 2'd0;
                        r_num_load   <= 5'd0;
                        r_num_choose <= 5'd0;
                        r_game_over  <= 1'b0;
                    end
                    default: r_state <= S_MENU;
                endcase
            end
        end
    end

    assign oResetBoard  = r_reset_board;
    assign oLoadEnable  = r_load_en;
    assign oNumToLoad   = r_num_load;
    assign oShowEnable  = r_show;
    assign oNumToChoose = r_num_choose;
    assign oLevel       = r_level;
    assign oStrikes     = r_strikes;
    assign oCorrect     = r_correct;
    assign oWrong       = r_wrong;
    assign oGameOver    = r_game_over;
    assign oState       = r_state;
endmodule

// File: tb/tb_chimp_sequencer.sv
// tb/tb_chimp_sequencer.sv - Directed self-checking bench for chimp_sequencer.
module tb_chimp_sequencer;
    logic       clk = 1'b0;
    logic       iReset, iKey0, iEnter, iDoneLoad, iClickValid;
    logic [4:0] iClickNum;
    logic       oResetBoard, oLoadEnable, oShowEnable, oCorrect, oWrong, oGameOver;
    logic [4:0] oNumToLoad, oNumToChoose, oLevel;
    logic [1:0] oStrikes;
    logic [2:0] oState;
    int         n_tests = 0;
    int         n_fail  = 0;

    chimp_sequencer dut (
        .clk(clk), .iReset(iReset), .iKey0(iKey0), .iEnter(iEnter), .iDoneLoad(iDoneLoad),
        .iClickValid(iClickValid), .iClickNum(iClickNum), .oResetBoard(oResetBoard),
        .oLoadEnable(oLoadEnable), .oNumToLoad(oNumToLoad), .oShowEnable(oShowEnable),
        .oNumToChoose(oNumToChoose), .oLevel(oLevel), .oStrikes(oStrikes), .oCorrect(oCorrect),
        .oWrong(oWrong), .oGameOver(oGameOver), .oState(oState)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic click(input int k);
        iClickValid = 1'b1;
        iClickNum   = 5'(k);
        step();
        iClickValid = 1'b0;
        iClickNum   = 5'd0;
    endtask

    // Answers every LOAD cycle; returns the highest number placed (0 on timeout).
    task automatic run_load(output int loaded);
        loaded    = 0;
        iDoneLoad = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (oState != 3'd2) break;
            loaded = int'(oNumToLoad);
            step();
        end
        if (oState == 3'd2) loaded = 0;
        iDoneLoad = 1'b0;
    endtask

    task automatic play_level(input int cnt);
        for (int k = 1; k <= cnt; k++) click(k);
        step();
        step();
    endtask

    task automatic test_reset();
        iReset = 1'b0; iKey0 = 1'b0; iEnter = 1'b0; iDoneLoad = 1'b0;
        iClickValid = 1'b0; iClickNum = 5'd0;
        step(); step();
        n_tests++;
        if ({oState, oLevel, oStrikes, oNumToLoad, oNumToChoose, oResetBoard, oLoadEnable,
             oShowEnable, oCorrect, oWrong, oGameOver} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d level=%0d strikes=%0d want all 0", oState, oLevel, oStrikes);
        end
        iReset = 1'b1;
        step();
        n_tests++;
        if (oState !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_menu: state=%0d want 0", oState);
        end
    endtask

    task automatic test_start_level1();
        int loaded;
        int ones;
        iEnter = 1'b1;
        step();
        iEnter = 1'b0;
        n_tests++;
        if ({oState, oResetBoard, oLevel, oStrikes, oNumToLoad} !== {3'd1, 1'b1, 5'd1, 2'd0, 5'd1}) begin
            n_fail++;
            $display("FAIL enter_clear: state=%0d rb=%0d level=%0d load=%0d want 1,1,1,1", oState, oResetBoard, oLevel, oNumToLoad);
        end
        ones = int'(oResetBoard);
        step();
        ones += int'(oResetBoard);
        n_tests++;
        if ({oState, oLoadEnable, oNumToLoad, ones[1:0]} !== {3'd2, 1'b1, 5'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL clear_to_load: state=%0d le=%0d load=%0d rb_cycles=%0d want 2,1,1,1", oState, oLoadEnable, oNumToLoad, ones);
        end
        iDoneLoad = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if ({oState, oNumToLoad} !== {3'd2, 5'(i)}) begin
                n_fail++;
                $display("FAIL load_seq: state=%0d load=%0d want 2,%0d", oState, oNumToLoad, i);
            end
            step();
        end
        iDoneLoad = 1'b0;
        loaded = 0;
        n_tests++;
        if ({oState, oShowEnable, oNumToChoose, oLoadEnable} !== {3'd3, 1'b1, 5'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL enter_show: state=%0d show=%0d choose=%0d le=%0d want 3,1,1,0", oState, oShowEnable, oNumToChoose, oLoadEnable);
        end
    endtask

    task automatic test_clear_level1();
        int n_corr = 0;
        int n_wr   = 0;
        int loaded;
        for (int k = 1; k <= 4; k++) begin
            click(k);
            n_corr += int'(oCorrect);
            n_wr   += int'(oWrong);
            if (k == 1) begin
                n_tests++;
                if ({oState, oShowEnable, oNumToChoose} !== {3'd4, 1'b0, 5'd2}) begin
                    n_fail++;
                    $display("FAIL first_pick: state=%0d show=%0d choose=%0d want 4,0,2", oState, oShowEnable, oNumToChoose);
                end
            end
        end
        n_tests++;
        if ({oState, oLevel} !== {3'd5, 5'd1}) begin
            n_fail++;
            $display("FAIL win_state: state=%0d level=%0d want 5,1", oState, oLevel);
        end
        step();
        n_corr += int'(oCorrect);
        n_tests++;
        if ({oState, oLevel, n_corr[3:0], n_wr[3:0]} !== {3'd1, 5'd2, 4'd4, 4'd0}) begin
            n_fail++;
            $display("FAIL level_up: state=%0d level=%0d correct=%0d wrong=%0d want 1,2,4,0", oState, oLevel, n_corr, n_wr);
        end
        step();
        run_load(loaded);
        n_tests++;
        if (loaded != 5 || oState !== 3'd3) begin
            n_fail++;
            $display("FAIL level2_load: loaded=%0d state=%0d want 5,3", loaded, oState);
        end
    endtask

    task automatic test_wrong_pick();
        click(1);
        click(3);
        n_tests++;
        if ({oState, oWrong, oCorrect} !== {3'd6, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrong_pulse: state=%0d wrong=%0d correct=%0d want 6,1,0", oState, oWrong, oCorrect);
        end
        step();
        n_tests++;
        if ({oState, oStrikes, oLevel, oWrong} !== {3'd1, 2'd1, 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL strike_clear: state=%0d strikes=%0d level=%0d wrong=%0d want 1,1,2,0", oState, oStrikes, oLevel, oWrong);
        end
    endtask

    task automatic test_gameover();
        int loaded;
        step();
        run_load(loaded);
        click(2);
        step();
        n_tests++;
        if ({oState, oStrikes} !== {3'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL second_strike: state=%0d strikes=%0d want 1,2", oState, oStrikes);
        end
        step();
        run_load(loaded);
        click(5);
        step();
        n_tests++;
        if ({oState, oGameOver, oStrikes, oLevel} !== {3'd7, 1'b1, 2'd3, 5'd2}) begin
            n_fail++;
            $display("FAIL gameover: state=%0d go=%0d strikes=%0d level=%0d want 7,1,3,2", oState, oGameOver, oStrikes, oLevel);
        end
        step();
        n_tests++;
        if ({oState, oStrikes} !== {3'd7, 2'd3}) begin
            n_fail++;
            $display("FAIL gameover_hold: state=%0d strikes=%0d want 7,3", oState, oStrikes);
        end
        iEnter = 1'b1;
        step();
        iEnter = 1'b0;
        n_tests++;
        if ({oState, oLevel, oStrikes, oGameOver} !== 11'd0) begin
            n_fail++;
            $display("FAIL gameover_exit: state=%0d level=%0d strikes=%0d go=%0d want 0", oState, oLevel, oStrikes, oGameOver);
        end
    endtask

    task automatic test_priority();
        int loaded;
        iEnter = 1'b1; step(); iEnter = 1'b0; step();
        iDoneLoad = 1'b1; iClickValid = 1'b1; iClickNum = 5'd1;
        step();
        iClickValid = 1'b0; iClickNum = 5'd0;
        n_tests++;
        if ({oState, oNumToLoad, oCorrect, oWrong} !== {3'd2, 5'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL click_in_load: state=%0d load=%0d c=%0d w=%0d want 2,2,0,0", oState, oNumToLoad, oCorrect, oWrong);
        end
        iKey0 = 1'b1;
        step();
        iKey0 = 1'b0; iDoneLoad = 1'b0;
        n_tests++;
        if ({oState, oLevel, oStrikes, oNumToLoad, oNumToChoose, oLoadEnable} !== 21'd0) begin
            n_fail++;
            $display("FAIL key0_priority: state=%0d level=%0d load=%0d le=%0d want 0", oState, oLevel, oNumToLoad, oLoadEnable);
        end
        iEnter = 1'b1; step(); iEnter = 1'b0; step();
        run_load(loaded);
        click(0);
        n_tests++;
        if ({oState, oShowEnable, oNumToChoose, oCorrect, oWrong} !== {3'd3, 1'b1, 5'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_click: state=%0d show=%0d choose=%0d c=%0d w=%0d want 3,1,1,0,0", oState, oShowEnable, oNumToChoose, oCorrect, oWrong);
        end
    endtask

    task automatic test_cap_async_reset();
        int loaded;
        for (int lvl = 1; lvl <= 5; lvl++) begin
            play_level(lvl + 3);
            run_load(loaded);
        end
        n_tests++;
        if (loaded != 9 || oLevel !== 5'd6) begin
            n_fail++;
            $display("FAIL level6_count: loaded=%0d level=%0d want 9,6", loaded, oLevel);
        end
        play_level(9);
        run_load(loaded);
        n_tests++;
        if (loaded != 9 || oLevel !== 5'd7 || oState !== 3'd3) begin
            n_fail++;
            $display("FAIL level7_cap: loaded=%0d level=%0d state=%0d want 9,7,3", loaded, oLevel, oState);
        end
        click(1);
        iClickValid = 1'b1; iClickNum = 5'd2;
        #2 iReset = 1'b0;
        #1;
        n_tests++;
        if ({oState, oLevel, oStrikes, oNumToLoad, oNumToChoose, oResetBoard, oLoadEnable,
             oShowEnable, oCorrect, oWrong, oGameOver} !== 28'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d level=%0d choose=%0d c=%0d want all 0", oState, oLevel, oNumToChoose, oCorrect);
        end
        step();
        iClickValid = 1'b0; iClickNum = 5'd0;
        iReset = 1'b1;
        step();
        n_tests++;
        if ({oState, oCorrect, oWrong, oLevel} !== 10'd0) begin
            n_fail++;
            $display("FAIL post_reset: state=%0d c=%0d w=%0d level=%0d want 0", oState, oCorrect, oWrong, oLevel);
        end
    endtask

    initial begin
        test_reset();
        test_start_level1();
        test_clear_level1();
        test_wrong_pick();
        test_gameover();
        test_priority();
        test_cap_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/chimp_sequencer.md
CHIMP_SEQUENCER -- requirements
Module: chimp_sequencer

Interface
REQ-001 SHALL have parameters:
- START_NUMS, default 4, numbers placed on level 1.
- MAX_NUMS, default 9, board capacity (3x3).
- MAX_STRIKES, default 3, wrong picks allowed before game over.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- iReset, in, 1, asynchronous active-low reset.
- iKey0, in, 1, return-to-menu request, active high, synchronous.
- iEnter, in, 1, start/continue pulse.
- iDoneLoad, in, 1, datapath has placed the number on oNumToLoad.
- iClickValid, in, 1, one-cycle pulse: a board box was clicked.
- iClickNum, in, 5, number in the clicked box; 0 = empty box.
- oResetBoard, out, 1, clear datapath board.
- oLoadEnable, out, 1, request datapath to place oNumToLoad.
- oNumToLoad, out, 5, number being placed.
- oShowEnable, out, 1, numbers visible.
- oNumToChoose, out, 5, next expected number.
- oLevel, out, 5, current level, 1-based.
- oStrikes, out, 2, wrong picks this game.
- oCorrect, out, 1, one-cycle pulse on a correct pick.
- oWrong, out, 1, one-cycle pulse on a wrong pick.
- oGameOver, out, 1, high in GAMEOVER.
- oState, out, 3, state encoding for debug.

Function
REQ-003 SHALL implement states MENU=0, CLEAR=1, LOAD=2, SHOW=3, PLAY=4, WIN=5, STRIKE=6, GAMEOVER=7; oState SHALL equal the current state.
REQ-004 SHALL define count = min(START_NUMS + oLevel - 1, MAX_NUMS).
REQ-005 MENU: all outputs 0; on iEnter=1, set oLevel=1 and oStrikes=0, then go to CLEAR.
REQ-006 CLEAR: oResetBoard=1 for exactly one cycle; set oNumToLoad=1; next state LOAD.
REQ-007 LOAD: oLoadEnable=1 while in state.
- On iDoneLoad=1 with oNumToLoad<count: oNumToLoad increments.
- On iDoneLoad=1 with oNumToLoad==count: go to SHOW with oNumToChoose=1.
- iDoneLoad outside LOAD SHALL be ignored.
REQ-008 SHOW: oShowEnable=1; PLAY: oShowEnable=0. oShowEnable is registered, i.e. it changes on the same edge as the state.
REQ-009 SHOW/PLAY click handling (iClickValid=1):
- iClickNum==0: ignored.
- iClickNum==oNumToChoose: oCorrect pulses next cycle. If oNumToChoose==count, go to WIN; otherwise oNumToChoose increments and the state becomes PLAY (numbers hidden after the first correct pick).
- Any other nonzero value: oWrong pulses next cycle; go to STRIKE.
REQ-010 iClickValid in any state other than SHOW/PLAY SHALL be ignored, including when it coincides with iDoneLoad.
REQ-011 WIN: one cycle; oLevel increments, saturating at 31; next state CLEAR.
REQ-012 STRIKE: one cycle; oStrikes increments.
- If the new value == MAX_STRIKES: go to GAMEOVER.
- Otherwise: go to CLEAR at the same level.
REQ-013 GAMEOVER: oGameOver=1; oLevel and oStrikes hold; iEnter=1 returns to MENU.
REQ-014 iKey0=1 in any state SHALL force MENU on the next edge and clear oLevel, oStrikes, oNumToLoad and oNumToChoose; this has priority over every other transition.
REQ-015 Once count reaches MAX_NUMS, further levels SHALL keep count=MAX_NUMS; oLevel still increments.
REQ-016 oCorrect and oWrong SHALL never both be 1; each SHALL be high for exactly one cycle per pick.

Reset
REQ-017 iReset=0 SHALL immediately and asynchronously set state=MENU and drive every output and counter to 0.
REQ-018 Release of iReset SHALL be sampled synchronously; the first transition can occur on the first rising edge after release.
REQ-019 Reset asserted mid-LOAD or mid-PLAY SHALL abandon the round with no oCorrect or oWrong pulse.

Verification
REQ-020 Start, level 1:
- Stimulus: iEnter; answer each LOAD cycle with iDoneLoad.
- Required: oResetBoard is 1 for one cycle; oNumToLoad runs 1,2,3,4; SHOW is entered with oNumToChoose=1.
REQ-021 Clear level 1:
- Stimulus: click iClickNum 1, 2, 3, 4 in order.
- Required: oShowEnable falls after the first click; 4 oCorrect pulses; WIN is entered; oLevel=2; the next LOAD loads 5 numbers.
REQ-022 Wrong pick:
- Stimulus: in PLAY with oNumToChoose=2, click iClickNum=3.
- Required: oWrong pulses; oStrikes=1; CLEAR follows; oLevel is unchanged.
REQ-023 Game over and return:
- Stimulus: three wrong picks, then iEnter.
- Required: GAMEOVER is entered with oGameOver=1 and oStrikes=3; iEnter returns to MENU.
REQ-024 Priority and ignored inputs:
- Stimulus: iKey0 during LOAD at the same cycle as iDoneLoad; separately, iClickNum=0 during SHOW.
- Required: iKey0 gives MENU next cycle with all counters 0; the empty click produces no pulse and no state change.
REQ-025 Cap and async reset:
- Stimulus: reach oLevel=6 (count 9), then assert iReset low between clock edges.
- Required: count stays 9 at oLevel=7; outputs go to 0 before the next edge.
